// File: rtl/rx_byte_packer.sv
// rx_byte_packer: packs received UART bytes into a frame and offers it to the sorter with a valid/ack handshake
module rx_byte_packer #(
  parameter int NUM_BYTES      = 8,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           byte_valid,
  input  logic [7:0]                     byte_in,
  input  logic                           array_ack,
  output logic [8*NUM_BYTES-1:0]         array_out,
  output logic                           array_valid,
  output logic [$clog2(NUM_BYTES+1)-1:0] byte_count,
  output logic                           overflow_err,
  output logic                           timeout_err
);
  localparam int CW = $clog2(NUM_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_BYTES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;
  state_t state, state_n;
  logic [8*NUM_BYTES-1:0] array_n;
  logic [CW-1:0] count_n, slot, slot_inc;
  logic [TW-1:0] timer, timer_n;
  logic valid_n, ovf_n, to_n, store;
  // register state and all outputs; reset asserts asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      array_out    <= '0;
      array_valid  <= 1'b0;
      byte_count   <= '0;
      timer        <= '0;
      overflow_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_n;
      array_out    <= array_n;
      array_valid  <= valid_n;
      byte_count   <= count_n;
      timer        <= timer_n;
      overflow_err <= ovf_n;
      timeout_err  <= to_n;
    end
  end
  // next-state: a byte is accepted unless the frame is waiting for the sorter without an ack this cycle
  always_comb begin
    state_n  = state;
    array_n  = array_out;
    count_n  = byte_count;
    timer_n  = timer;
    valid_n  = array_valid;
    ovf_n    = 1'b0;
    to_n     = 1'b0;
    store    = byte_valid && (state != FULL || array_ack);
    slot     = (state == COLLECT) ? byte_count : '0;
    slot_inc = slot + CW'(1);
    case (state)
      COLLECT: begin
        if (!byte_valid && timer == T_LAST) begin
          count_n = '0;
          timer_n = '0;
          to_n    = 1'b1;
          state_n = IDLE;
        end else if (!byte_valid) begin
          timer_n = timer + TW'(1);
        end
      end
      FULL: begin
        if (array_ack) begin
          valid_n = 1'b0;
          count_n = '0;
          state_n = IDLE;
        end else begin
          ovf_n = byte_valid;
        end
      end
      IDLE: ;
      default: state_n = IDLE;
    endcase
    if (store) begin
      array_n[{slot, 3'b000} +: 8] = byte_in;
      count_n = slot_inc;
      timer_n = '0;
      valid_n = (slot_inc == LAST_CNT);
      state_n = (slot_inc == LAST_CNT) ? FULL : COLLECT;
    end
  end
endmodule

// File: tb/tb_rx_byte_packer.sv
// tb_rx_byte_packer: directed and randomized checks of rx_byte_packer against a frame-level reference model
module tb_rx_byte_packer;
  localparam int NB = 8;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic byte_valid = 1'b0;
  logic [7:0] byte_in = '0;
  logic array_ack = 1'b0;
  logic [63:0] array_out;
  logic array_valid;
  logic [3:0] byte_count;
  logic overflow_err, timeout_err;
  int checks = 0;
  int errors = 0;
  logic [7:0] m_slots [NB];
  int m_cnt, m_idle;
  bit m_full, m_ovf, m_to;

  rx_byte_packer #(.NUM_BYTES(NB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_in(byte_in),
    .array_ack(array_ack), .array_out(array_out), .array_valid(array_valid),
    .byte_count(byte_count), .overflow_err(overflow_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] m_arr();
    logic [63:0] r;
    for (int i = 0; i < NB; i++) r[8*i +: 8] = m_slots[i];
    return r;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NB; i++) m_slots[i] = 8'h00;
    m_cnt = 0; m_idle = 0; m_full = 0; m_ovf = 0; m_to = 0;
  endtask

  // frame-level view: bytes accumulate until NB, idle cycles since last byte discard a partial frame
  task automatic m_step(input bit bv, input logic [7:0] b, input bit ack);
    m_ovf = 0; m_to = 0;
    if (m_full) begin
      if (ack) begin
        m_full = 0; m_cnt = 0;
        if (bv) begin m_slots[0] = b; m_cnt = 1; m_idle = 0; end
      end else if (bv) m_ovf = 1;
    end else if (bv) begin
      m_slots[m_cnt] = b; m_cnt++; m_idle = 0;
      if (m_cnt == NB) m_full = 1;
    end else if (m_cnt > 0) begin
      m_idle++;
      if (m_idle == TO) begin m_cnt = 0; m_idle = 0; m_to = 1; end
    end
  endtask

  task automatic tick(input bit bv, input logic [7:0] b, input bit ack);
    byte_valid = bv; byte_in = b; array_ack = ack;
    @(posedge clk);
    m_step(bv, b, ack);
    #1;
    byte_valid = 1'b0; array_ack = 1'b0;
  endtask

  task automatic do_reset();
    byte_valid = 1'b0; array_ack = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({array_out, array_valid, byte_count, overflow_err, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset: out=%h valid=%b cnt=%0d ovf=%b to=%b, need all zero", array_out, array_valid, byte_count, overflow_err, timeout_err);
    end
  endtask

  task automatic test_frame();
    logic [7:0] seq [8] = '{8'h38, 8'h31, 8'h37, 8'h32, 8'h35, 8'h30, 8'h39, 8'h33};
    do_reset();
    for (int i = 0; i < 7; i++) tick(1, seq[i], 0);
    checks++;
    if (array_valid !== 1'b0 || byte_count !== 4'd7) begin
      errors++;
      $display("FAIL frame_partial: valid=%b cnt=%0d, need 0/7", array_valid, byte_count);
    end
    tick(1, seq[7], 0);
    checks++;
    if (array_valid !== 1'b1 || byte_count !== 4'd8 || array_out !== 64'h3339303532373138) begin
      errors++;
      $display("FAIL frame_full: valid=%b cnt=%0d out=%h, need 1/8/3339303532373138", array_valid, byte_count, array_out);
    end
  endtask

  task automatic test_overflow();
    tick(1, 8'h41, 0);
    checks++;
    if (overflow_err !== 1'b1 || array_out !== 64'h3339303532373138 || array_valid !== 1'b1) begin
      errors++;
      $display("FAIL overflow_pulse: ovf=%b out=%h valid=%b, need 1/3339303532373138/1", overflow_err, array_out, array_valid);
    end
    tick(0, 8'h00, 0);
    checks++;
    if (overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL overflow_single: ovf=%b, need 0", overflow_err);
    end
    tick(0, 8'h00, 1);
    checks++;
    if (array_valid !== 1'b0 || byte_count !== 4'd0 || overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL ack_release: valid=%b cnt=%0d ovf=%b, need 0/0/0", array_valid, byte_count, overflow_err);
    end
  endtask

  task automatic test_timeout();
    int early = 0;
    do_reset();
    for (int i = 0; i < 3; i++) tick(1, 8'(8'hA0 + i), 0);
    for (int i = 0; i < TO - 1; i++) begin
      tick(0, 8'h00, 0);
      if (timeout_err !== 1'b0 || byte_count !== 4'd3) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL timeout_early: %0d early cycles, need 0", early);
    end
    tick(0, 8'h00, 0);
    checks++;
    if (timeout_err !== 1'b1 || byte_count !== 4'd0) begin
      errors++;
      $display("FAIL timeout_pulse: to=%b cnt=%0d, need 1/0", timeout_err, byte_count);
    end
    for (int i = 0; i < NB; i++) tick(1, 8'(8'h10 + i), 0);
    checks++;
    if (timeout_err !== 1'b0 || array_valid !== 1'b1 || array_out !== 64'h1716151413121110) begin
      errors++;
      $display("FAIL timeout_refill: to=%b valid=%b out=%h, need 0/1/1716151413121110", timeout_err, array_valid, array_out);
    end
  endtask

  task automatic test_expiry_strobe();
    do_reset();
    for (int i = 0; i < 3; i++) tick(1, 8'(8'hC0 + i), 0);
    for (int i = 0; i < TO - 1; i++) tick(0, 8'h00, 0);
    tick(1, 8'hC3, 0);
    checks++;
    if (timeout_err !== 1'b0 || byte_count !== 4'd4 || array_out[31:0] !== 32'hC3C2C1C0) begin
      errors++;
      $display("FAIL expiry_strobe: to=%b cnt=%0d low=%h, need 0/4/c3c2c1c0", timeout_err, byte_count, array_out[31:0]);
    end
  endtask

  task automatic test_ack_and_byte();
    do_reset();
    for (int i = 0; i < NB; i++) tick(1, 8'(8'h60 + i), 0);
    tick(1, 8'h55, 1);
    checks++;
    if (array_valid !== 1'b0 || byte_count !== 4'd1 || array_out[7:0] !== 8'h55 || overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL ack_byte: valid=%b cnt=%0d b0=%h ovf=%b, need 0/1/55/0", array_valid, byte_count, array_out[7:0], overflow_err);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) tick(1, 8'(8'h70 + i), 0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({array_out, array_valid, byte_count, overflow_err, timeout_err} !== '0) begin
      errors++;
      $display("FAIL async_mid: out=%h cnt=%0d, need 0/0", array_out, byte_count);
    end
    @(negedge clk); rst = 1'b0; m_reset();
    @(posedge clk); #1;
    for (int i = 0; i < NB; i++) tick(1, 8'(8'h80 + i), 0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({array_out, array_valid, byte_count, overflow_err, timeout_err} !== '0) begin
      errors++;
      $display("FAIL async_full: out=%h valid=%b cnt=%0d, need all zero", array_out, array_valid, byte_count);
    end
    @(negedge clk); rst = 1'b0; m_reset();
    @(posedge clk); #1;
    tick(0, 8'h00, 1);
    checks++;
    if (array_valid !== 1'b0 || byte_count !== 4'd0 || array_out !== 64'h0) begin
      errors++;
      $display("FAIL stray_ack: valid=%b cnt=%0d out=%h, need 0/0/0", array_valid, byte_count, array_out);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    int busy;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      busy = ((c / 100) % 3 == 2) ? 6 : 50;
      tick(($urandom % 100) < busy, 8'($urandom), ($urandom % 100) < 20);
      if (array_out !== m_arr() || array_valid !== m_full || byte_count !== 4'(m_cnt) || overflow_err !== m_ovf || timeout_err !== m_to) begin
        bad++;
        if (bad < 5) $display("FAIL random cycle %0d: out=%h v=%b c=%0d o=%b t=%b, need out=%h v=%b c=%0d o=%b t=%b", c, array_out, array_valid, byte_count, overflow_err, timeout_err, m_arr(), m_full, m_cnt, m_ovf, m_to);
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL random: %0d divergent cycles, need 0", bad);
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_frame();
    test_overflow();
    test_timeout();
    test_expiry_strobe();
    test_ack_and_byte();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
